rv_plic_claimer: RTL and testbench



---
 rtl/rv_plic_claimer_pkg.sv | 51 +++++
 rtl/rv_plic_claimer_if.sv | 10 +
 rtl/rv_plic_claimer_holdoff.sv | 32 +++
 rtl/rv_plic_claimer.sv | 173 +++++++++++++++++
 tb/tb_rv_plic_claimer.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_plic_claimer_pkg.sv
// Shared types for the PLIC claim/complete engine: a minimal TL-UL host/device
// channel view (opcode encodings match tlul_pkg) and the FSM state encoding.
package rv_plic_claimer_pkg;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic        a_valid;
        tl_a_op_e    a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        tl_d_op_e    d_opcode;
        logic [7:0]  d_source;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

    localparam logic [1:0] CC_SIZE = 2'd2;
    localparam logic [3:0] CC_MASK = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLAIM_REQ,
        ST_CLAIM_RSP,
        ST_DISPATCH,
        ST_SERVICE,
        ST_COMP_REQ,
        ST_COMP_RSP,
        ST_HOLDOFF
    } claimer_state_e;

endpackage

// File: rtl/rv_plic_claimer_if.sv
// TL-UL link between the claimer (host) and the PLIC register port (device).
interface rv_plic_claimer_if;
    import rv_plic_claimer_pkg::*;

    tl_h2d_t tl_o;
    tl_d2h_t tl_i;

    modport host   (output tl_o, input tl_i);
    modport device (input tl_o, output tl_i);
endinterface

// File: rtl/rv_plic_claimer_holdoff.sv
// Loadable down-counter; done_o is high whenever the count has reached zero.
module rv_plic_claimer_holdoff #(
    parameter int unsigned CntW = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic [CntW-1:0] load_val_i,
    input  logic            dec_i,
    output logic            done_o
);
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);
endmodule

// File: rtl/rv_plic_claimer.sv
// Claim/complete engine for one PLIC target: claims on irq, hands the ID to a
// consumer, completes after done. Optional counters: RV_PLIC_CLAIMER_STATS_EN.
module rv_plic_claimer
    import rv_plic_claimer_pkg::*;
#(
    parameter logic [31:0] CcAddr        = 32'h0000_0200,
    parameter int unsigned IdW           = 6,
    parameter logic [7:0]  SourceId      = 8'd0,
    parameter int unsigned HoldoffCycles = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    rv_plic_claimer_if.host    tl,
    input  logic               irq_i,
    output logic               id_valid_o,
    output logic [IdW-1:0]     id_o,
    input  logic               id_ready_i,
    input  logic               done_i,
    output logic               busy_o,
    output logic               err_o
`ifdef RV_PLIC_CLAIMER_STATS_EN
    ,
    output logic [15:0]        claim_cnt_o,
    output logic [15:0]        spurious_cnt_o,
    output logic [7:0]         err_cnt_o
`endif
);
    localparam int unsigned HoldW = (HoldoffCycles > 1) ? $clog2(HoldoffCycles) : 1;
    localparam int unsigned HoldLoadInt = (HoldoffCycles > 0) ? HoldoffCycles - 1 : 0;
    localparam logic [HoldW-1:0] HoldLoad = HoldW'(HoldLoadInt);

    claimer_state_e state_q, state_d;
    logic [IdW-1:0] id_q, id_d;
    logic           err_q, err_d;
    logic           hold_load, hold_dec, hold_done;
    tl_h2d_t        h2d;
    logic [IdW-1:0] rsp_id;
    logic           claim_rsp_bad, comp_rsp_bad;
    logic           unused_d_data;

    assign rsp_id        = tl.tl_i.d_data[IdW-1:0];
    assign unused_d_data = ^tl.tl_i.d_data[31:IdW];
    assign claim_rsp_bad = tl.tl_i.d_error || (tl.tl_i.d_opcode != AccessAckData)
                           || (tl.tl_i.d_source != SourceId);
    assign comp_rsp_bad  = tl.tl_i.d_error || (tl.tl_i.d_opcode != AccessAck)
                           || (tl.tl_i.d_source != SourceId);

    rv_plic_claimer_holdoff #(.CntW(HoldW)) u_holdoff (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (hold_load),
        .load_val_i (HoldLoad),
        .dec_i      (hold_dec),
        .done_o     (hold_done)
    );

    always_comb begin
        state_d       = state_q;
        id_d          = id_q;
        err_d         = 1'b0;
        hold_load     = 1'b0;
        hold_dec      = 1'b0;
        h2d           = '0;
        h2d.a_opcode  = Get;
        h2d.a_size    = CC_SIZE;
        h2d.a_mask    = CC_MASK;
        h2d.a_source  = SourceId;
        h2d.a_address = CcAddr;
        h2d.d_ready   = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                err_d = tl.tl_i.d_valid;
                if (irq_i) state_d = ST_CLAIM_REQ;
            end
            ST_CLAIM_REQ: begin
                h2d.a_valid = 1'b1;
                err_d       = tl.tl_i.d_valid;
                if (tl.tl_i.a_ready) state_d = ST_CLAIM_RSP;
            end
            ST_CLAIM_RSP: begin
                if (tl.tl_i.d_valid) begin
                    if (claim_rsp_bad || (rsp_id == '0)) begin
                        err_d     = claim_rsp_bad;
                        state_d   = (HoldoffCycles == 0) ? ST_IDLE : ST_HOLDOFF;
                        hold_load = (HoldoffCycles != 0);
                    end else begin
                        id_d    = rsp_id;
                        state_d = ST_DISPATCH;
                    end
                end
            end
            // The consumer owns the ID here; D is held off so nothing can land.
            ST_DISPATCH: begin
                h2d.d_ready = 1'b0;
                if (id_ready_i) state_d = ST_SERVICE;
            end
            ST_SERVICE: begin
                h2d.d_ready = 1'b0;
                if (done_i) state_d = ST_COMP_REQ;
            end
            ST_COMP_REQ: begin
                h2d.a_valid  = 1'b1;
                h2d.a_opcode = PutFullData;
                h2d.a_data   = 32'(id_q);
                err_d        = tl.tl_i.d_valid;
                if (tl.tl_i.a_ready) state_d = ST_COMP_RSP;
            end
            ST_COMP_RSP: begin
                if (tl.tl_i.d_valid) begin
                    err_d     = comp_rsp_bad;
                    state_d   = (HoldoffCycles == 0) ? ST_IDLE : ST_HOLDOFF;
                    hold_load = (HoldoffCycles != 0);
                end
            end
            ST_HOLDOFF: begin
                err_d = tl.tl_i.d_valid;
                if (hold_done) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_dec = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            id_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            err_q   <= err_d;
        end
    end

    assign tl.tl_o    = h2d;
    assign id_valid_o = (state_q == ST_DISPATCH);
    assign id_o       = id_q;
    assign busy_o     = (state_q != ST_IDLE) && (state_q != ST_HOLDOFF);
    assign err_o      = err_q;

`ifdef RV_PLIC_CLAIMER_STATS_EN
    logic [15:0] claim_cnt_q, spurious_cnt_q;
    logic [7:0]  err_cnt_q;
    logic        claim_accept;

    assign claim_accept = (state_q == ST_CLAIM_RSP) && tl.tl_i.d_valid && !claim_rsp_bad;

    // Counters saturate instead of wrapping so a stuck source stays visible.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            claim_cnt_q    <= '0;
            spurious_cnt_q <= '0;
            err_cnt_q      <= '0;
        end else begin
            if (claim_accept && (rsp_id != '0) && (claim_cnt_q != 16'hFFFF))
                claim_cnt_q <= claim_cnt_q + 16'd1;
            if (claim_accept && (rsp_id == '0) && (spurious_cnt_q != 16'hFFFF))
                spurious_cnt_q <= spurious_cnt_q + 16'd1;
            if (err_d && (err_cnt_q != 8'hFF))
                err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign claim_cnt_o    = claim_cnt_q;
    assign spurious_cnt_o = spurious_cnt_q;
    assign err_cnt_o      = err_cnt_q;
`endif
endmodule

// File: tb/tb_rv_plic_claimer.sv
// Randomised bench for rv_plic_claimer against a transaction-level model of
// claim, dispatch, complete and holdoff behaviour.
module tb_rv_plic_claimer;
    import rv_plic_claimer_pkg::*;

    localparam logic [31:0] CC_ADDR = 32'h0000_0200;
    localparam int          IDW     = 6;
    localparam int          HOLD    = 2;
    localparam logic [7:0]  SRC     = 8'd0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rv_plic_claimer_if bus ();
    logic           irq, id_valid, id_ready, done, busy, err;
    logic [IDW-1:0] id;
`ifdef RV_PLIC_CLAIMER_STATS_EN
    logic [15:0] claim_cnt, spur_cnt;
    logic [7:0]  err_cnt;
`endif

    rv_plic_claimer #(
        .CcAddr(CC_ADDR), .IdW(IDW), .SourceId(SRC), .HoldoffCycles(HOLD)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .tl         (bus),
        .irq_i      (irq),
        .id_valid_o (id_valid),
        .id_o       (id),
        .id_ready_i (id_ready),
        .done_i     (done),
        .busy_o     (busy),
        .err_o      (err)
`ifdef RV_PLIC_CLAIMER_STATS_EN
        ,
        .claim_cnt_o    (claim_cnt),
        .spurious_cnt_o (spur_cnt),
        .err_cnt_o      (err_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: what the engine owes the bus and the consumer right now.
    bit          m_busy, m_need_get, m_need_put, m_in_svc, m_id_taken, m_err;
    int          m_hold, m_out, m_dly;   // m_out: 0 none, 1 Get pending, 2 Put pending
    logic [31:0] m_rsp_data;
    bit          m_rsp_err;
    logic [5:0]  m_cur_id;
    int          m_claims, m_spur, m_errs;

    // Response the device will give to the next accepted request.
    logic [31:0] k_data;
    bit          k_err;
    int          k_dly;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_need_get = 0; m_need_put = 0; m_in_svc = 0; m_id_taken = 0;
        m_err = 0; m_hold = 0; m_out = 0; m_dly = 0; m_rsp_data = '0; m_rsp_err = 0;
        m_cur_id = '0; m_claims = 0; m_spur = 0; m_errs = 0;
    endtask

    task automatic terminal();
        m_busy = 0;
        m_hold = HOLD;
    endtask

    task automatic check_outputs();
        bit req;
        req = m_need_get || m_need_put;
        chk("a_valid",  32'(bus.tl_o.a_valid), 32'(req));
        chk("d_ready",  32'(bus.tl_o.d_ready), 32'(!m_in_svc));
        chk("id_valid", 32'(id_valid), 32'(m_in_svc && !m_id_taken));
        chk("busy",     32'(busy), 32'(m_busy));
        chk("err",      32'(err), 32'(m_err));
        if (req) begin
            chk("a_opcode",  32'(bus.tl_o.a_opcode), m_need_get ? 32'(Get) : 32'(PutFullData));
            chk("a_address", bus.tl_o.a_address, CC_ADDR);
            chk("a_size",    32'(bus.tl_o.a_size), 32'd2);
            chk("a_mask",    32'(bus.tl_o.a_mask), 32'hF);
            chk("a_source",  32'(bus.tl_o.a_source), 32'(SRC));
            if (m_need_put) chk("a_data", bus.tl_o.a_data, 32'(m_cur_id));
        end
        if (m_in_svc && !m_id_taken) chk("id_o", 32'(id), 32'(m_cur_id));
`ifdef RV_PLIC_CLAIMER_STATS_EN
        chk("claim_cnt", 32'(claim_cnt), 32'(m_claims));
        chk("spur_cnt",  32'(spur_cnt),  32'(m_spur));
        chk("err_cnt",   32'(err_cnt),   32'(m_errs));
`endif
    endtask

    // Called at a negedge: check, drive the next edge's inputs, advance model.
    task automatic step(input bit r, input bit irq_v, input bit ard, input bit idr,
                        input bit dn, input bit stray);
        bit dv, pre_busy, pre_svc, pre_taken;
        check_outputs();
        dv = stray || (m_out != 0 && m_dly == 0);
        rst = r; irq = irq_v; id_ready = idr; done = dn;
        bus.tl_i.a_ready  = ard;
        bus.tl_i.d_valid  = dv;
        bus.tl_i.d_opcode = (m_out == 1) ? AccessAckData : AccessAck;
        bus.tl_i.d_source = SRC;
        bus.tl_i.d_data   = stray ? $urandom : m_rsp_data;
        bus.tl_i.d_error  = stray ? 1'b0 : m_rsp_err;
        if (r) begin
            model_reset();
        end else begin
            pre_busy = m_busy; pre_svc = m_in_svc; pre_taken = m_id_taken;
            m_err = 0;
            if (m_out != 0 && m_dly > 0) m_dly--;
            if (dv && !pre_svc) begin
                if (m_out == 1 && !stray) begin
                    m_out = 0;
                    if (m_rsp_err) begin m_err = 1; terminal(); end
                    else if (m_rsp_data[5:0] == 6'd0) begin m_spur++; terminal(); end
                    else begin
                        m_claims++; m_in_svc = 1; m_id_taken = 0; m_cur_id = m_rsp_data[5:0];
                    end
                end else if (m_out == 2 && !stray) begin
                    m_out = 0;
                    if (m_rsp_err) m_err = 1;
                    terminal();
                end else begin
                    m_err = 1;
                end
            end
            if (m_need_get && ard) begin
                m_need_get = 0; m_out = 1; m_dly = k_dly; m_rsp_data = k_data; m_rsp_err = k_err;
            end else if (m_need_put && ard) begin
                m_need_put = 0; m_out = 2; m_dly = k_dly; m_rsp_data = '0; m_rsp_err = k_err;
            end
            if (pre_svc && pre_taken && dn) begin
                m_in_svc = 0; m_need_put = 1;
            end else if (pre_svc && !pre_taken && idr) begin
                m_id_taken = 1;
            end
            if (!pre_busy) begin
                if (m_hold > 0) m_hold--;
                else if (irq_v) begin m_busy = 1; m_need_get = 1; end
            end
            if (m_err && m_errs < 255) m_errs++;
        end
        @(negedge clk);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 1, 1, 1, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, cnt_a, cnt_i, cnt_e;
        logic [31:0] r32;
        irq = 0; id_ready = 0; done = 0;
        bus.tl_i = '0;
        k_data = 32'd5; k_err = 0; k_dly = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        model_reset();
        chk("rst_id_o", 32'(id), 32'd0);

        // Basic claim, dispatch latency, completion and holdoff timing.
        step(0, 1, 1, 0, 0, 0);
        n = 1;
        while (!id_valid && n < 20) begin step(0, 1, 1, 0, 0, 0); n++; end
        chk("irq_to_id_valid", 32'(n), 32'd3);
        chk("basic_id", 32'(id), 32'd5);
        step(0, 1, 1, 1, 0, 0);
        step(0, 1, 1, 0, 1, 0);
        chk("put_opcode", 32'(bus.tl_o.a_opcode), 32'(PutFullData));
        chk("put_data", bus.tl_o.a_data, 32'd5);
        step(0, 1, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        chk("busy_after_complete", 32'(busy), 32'd0);
        k_data = 32'd7; k_dly = 2;
        n = 0;
        while (!bus.tl_o.a_valid && n < 20) begin step(0, 1, 0, 0, 0, 0); n++; end
        chk("holdoff_to_get", 32'(n), 32'(HOLD + 1));

        // Backpressure on A and on the consumer handshake.
        cnt_a = 0;
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0, 0);
            if (bus.tl_o.a_valid) cnt_a++;
        end
        chk("bp_a_valid_held", 32'(cnt_a), 32'd4);
        step(0, 0, 1, 0, 0, 0);
        n = 0;
        while (!id_valid && n < 20) begin step(0, 0, 0, 0, 0, 0); n++; end
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
        chk("bp_id", 32'(id), 32'd7);
        drain(15);

        // Spurious claim: no dispatch, single request, no complete.
        k_data = 32'hABCD_EF40; k_dly = 0;
        cnt_a = 0; cnt_i = 0;
        step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            if (bus.tl_o.a_valid) cnt_a++;
            if (id_valid) cnt_i++;
            step(0, 0, 1, 1, 1, 0);
        end
        chk("spur_requests", 32'(cnt_a), 32'd1);
        chk("spur_no_dispatch", 32'(cnt_i), 32'd0);
`ifdef RV_PLIC_CLAIMER_STATS_EN
        chk("spur_cnt_one", 32'(spur_cnt), 32'd1);
`endif

        // Error response on the claim.
        k_data = 32'd9; k_err = 1;
        cnt_e = 0; cnt_i = 0;
        step(0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1, 1, 1, 0);
            if (err) cnt_e++;
            if (id_valid) cnt_i++;
        end
        chk("err_pulses", 32'(cnt_e), 32'd1);
        chk("err_no_dispatch", 32'(cnt_i), 32'd0);
        k_err = 0;

        // Reset in SERVICE, then a stray response in IDLE.
        k_data = 32'd12;
        step(0, 1, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("rst_id_valid", 32'(id_valid), 32'd0);
        chk("rst_a_valid", 32'(bus.tl_o.a_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        step(0, 0, 0, 0, 0, 1);
        chk("stray_err", 32'(err), 32'd1);
        step(0, 0, 0, 0, 0, 0);

        // Randomised traffic.
        for (int c = 0; c < 3000; c++) begin
            r32 = $urandom;
            if ($urandom_range(0, 99) < 15) r32[5:0] = 6'd0;
            else if (r32[5:0] == 6'd0) r32[5:0] = 6'd1;
            k_data = r32;
            k_err  = ($urandom_range(0, 9) == 0);
            k_dly  = $urandom_range(0, 3);
            step($urandom_range(0, 499) == 0, $urandom_range(0, 9) < 8,
                 $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 3) == 0, 0);
        end
        k_err = 0;
        drain(20);
        check_outputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
